// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared types and constants for the branch target buffer
package branch_target_buffer_pkg;

  typedef logic [31:0] word_t;

  localparam int         BTB_ENTRIES = 16;
  localparam logic [1:0] CNT_WEAK_T  = 2'b10;
  localparam logic [1:0] CNT_WEAK_NT = 2'b01;

  // Tag field sized for the smallest legal index; narrower tags are zero-extended.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    word_t       target;
    logic [1:0]  cnt;
  } btb_entry_t;

endpackage

// File: rtl/btb_if.sv
// rtl/btb_if.sv - bundle of the branch target buffer signals for lookup and training
interface btb_if
  import branch_target_buffer_pkg::*;
(
  input logic CLK
);
  logic        RST;
  word_t       cpc;
  logic        phit;
  word_t       baddr;
  logic        upd_en;
  word_t       upd_pc;
  logic        upd_taken;
  word_t       upd_target;
  logic        upd_mispred;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispred;
  logic        lookup_en;

  modport btb (
    input  CLK, RST, cpc, upd_en, upd_pc, upd_taken, upd_target, lookup_en,
    output phit, baddr, upd_mispred, stat_lookups, stat_mispred
  );

  modport tb (
    input  CLK, phit, baddr, upd_mispred, stat_lookups, stat_mispred,
    output RST, cpc, upd_en, upd_pc, upd_taken, upd_target, lookup_en
  );
endinterface

// File: rtl/branch_target_buffer_sat_cnt2.sv
// rtl/branch_target_buffer_sat_cnt2.sv - 2-bit saturating up/down counter next state
module sat_cnt2 (
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] cnt_n
);
  always_comb begin
    cnt_n = cnt;
    if (inc) begin
      if (cnt != 2'b11) cnt_n = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) cnt_n = cnt - 2'b01;
    end
  end
endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit direction counters
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter  int ENTRIES = BTB_ENTRIES,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  word_t       cpc,
  output logic        phit,
  output word_t       baddr,
  input  logic        upd_en,
  input  word_t       upd_pc,
  input  logic        upd_taken,
  input  word_t       upd_target,
  output logic        upd_mispred,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispred,
  input  logic        lookup_en
);

  btb_entry_t mem [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  btb_entry_t       rd_e, wr_e, new_e;
  logic             upd_hit, pred_taken, mispred_n, wr_we;
  logic [1:0]       cnt_n;
  logic             unused_pc_bits;

  assign rd_idx = cpc[IDX_W+1:2];
  assign rd_tag = cpc[31:IDX_W+2];
  assign wr_idx = upd_pc[IDX_W+1:2];
  assign wr_tag = upd_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{cpc[1:0], upd_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not visible yet.
  assign rd_e  = mem[rd_idx];
  assign phit  = rd_e.valid && (rd_e.tag == 30'(rd_tag)) && rd_e.cnt[1];
  assign baddr = rd_e.target;

  assign wr_e       = mem[wr_idx];
  assign upd_hit    = wr_e.valid && (wr_e.tag == 30'(wr_tag));
  assign pred_taken = upd_hit && wr_e.cnt[1];
  assign mispred_n  = upd_en && ((pred_taken != upd_taken) ||
                      (pred_taken && upd_taken && (wr_e.target != upd_target)));

  sat_cnt2 u_sat_cnt2 (
    .cnt   (wr_e.cnt),
    .inc   (upd_taken),
    .cnt_n (cnt_n)
  );

  always_comb begin
    new_e = wr_e;
    wr_we = 1'b0;
    if (upd_en) begin
      if (upd_hit) begin
        wr_we     = 1'b1;
        new_e.cnt = cnt_n;
        if (upd_taken) new_e.target = upd_target;
      end else if (upd_taken) begin
        wr_we = 1'b1;
        new_e = '{valid: 1'b1, tag: 30'(wr_tag), target: upd_target, cnt: CNT_WEAK_T};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WEAK_NT};
      end
      upd_mispred  <= 1'b0;
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (wr_we) mem[wr_idx] <= new_e;
      upd_mispred <= mispred_n;
      if (lookup_en && (stat_lookups != '1)) stat_lookups <= stat_lookups + 32'd1;
      if (mispred_n && (stat_mispred != '1)) stat_mispred <= stat_mispred + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] cpc;
  logic        phit;
  logic [31:0] baddr;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispred;
  logic        lookup_en;

  int tests = 0;
  int fails = 0;

  branch_target_buffer dut (
    .CLK          (CLK),
    .RST          (RST),
    .cpc          (cpc),
    .phit         (phit),
    .baddr        (baddr),
    .upd_en       (upd_en),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_mispred  (upd_mispred),
    .stat_lookups (stat_lookups),
    .stat_mispred (stat_mispred),
    .lookup_en    (lookup_en)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        phit;
    logic [31:0] baddr;
  } look_t;

  typedef struct packed {
    logic        mis;
    logic [31:0] sl;
    logic [31:0] sm;
  } post_t;

  look_t look_q[$];
  post_t post_q[$];

  // Reference model of the 16-entry table
  logic        m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [1:0]  m_cnt [16];
  logic [31:0] m_sl, m_sm;
  bit          m_known = 0;

  logic        obs_phit;
  logic [31:0] obs_baddr;
  logic        obs_mis;

  // Scoreboard: lookups checked mid-cycle, registered results the cycle after the edge
  always @(negedge CLK) begin
    look_t el;
    post_t ep;
    #2;
    if (look_q.size() != 0) begin
      el = look_q.pop_front();
      tests++;
      if ({phit, baddr} !== el) begin
        fails++;
        $display("FAIL sb_lookup cpc=%h: got phit=%0b baddr=%h, expected phit=%0b baddr=%h",
                 cpc, phit, baddr, el.phit, el.baddr);
      end
    end
    if (post_q.size() != 0) begin
      ep = post_q.pop_front();
      tests++;
      if (upd_mispred !== ep.mis) begin
        fails++;
        $display("FAIL sb_mispred: got %0b, expected %0b", upd_mispred, ep.mis);
      end
      tests++;
      if (stat_lookups !== ep.sl) begin
        fails++;
        $display("FAIL sb_stat_lookups: got %h, expected %h", stat_lookups, ep.sl);
      end
      tests++;
      if (stat_mispred !== ep.sm) begin
        fails++;
        $display("FAIL sb_stat_mispred: got %h, expected %h", stat_mispred, ep.sm);
      end
    end
  end

  task automatic step(input logic rst, input logic len, input logic [31:0] pc,
                      input logic ue, input logic [31:0] upc, input logic tk,
                      input logic [31:0] tgt);
    int  i, j;
    logic hit, pred, mis;
    @(negedge CLK);
    RST = rst; lookup_en = len; cpc = pc;
    upd_en = ue; upd_pc = upc; upd_taken = tk; upd_target = tgt;
    #1;
    i = int'(pc[5:2]);
    if (m_known)
      look_q.push_back('{m_v[i] && (m_tag[i] == pc[31:6]) && m_cnt[i][1], m_tgt[i]});
    obs_phit  = phit;
    obs_baddr = baddr;
    j    = int'(upc[5:2]);
    hit  = m_v[j] && (m_tag[j] == upc[31:6]);
    pred = hit && m_cnt[j][1];
    mis  = ue && ((pred != tk) || (pred && tk && (m_tgt[j] != tgt)));
    @(posedge CLK);
    #1;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_v[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_cnt[k] = 2'b01;
      end
      m_sl = '0; m_sm = '0; mis = 1'b0; m_known = 1;
    end else begin
      if (ue) begin
        if (hit) begin
          if (tk) begin
            m_cnt[j] = (m_cnt[j] == 2'b11) ? 2'b11 : m_cnt[j] + 2'b01;
            m_tgt[j] = tgt;
          end else begin
            m_cnt[j] = (m_cnt[j] == 2'b00) ? 2'b00 : m_cnt[j] - 2'b01;
          end
        end else if (tk) begin
          m_v[j] = 1'b1; m_tag[j] = upc[31:6]; m_tgt[j] = tgt; m_cnt[j] = 2'b10;
        end
      end
      if (len && (m_sl != 32'hFFFF_FFFF)) m_sl = m_sl + 32'd1;
      if (mis && (m_sm != 32'hFFFF_FFFF)) m_sm = m_sm + 32'd1;
    end
    if (m_known) post_q.push_back('{mis, m_sl, m_sm});
    obs_mis = upd_mispred;
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    step(1'b0, 1'b0, 32'h0, 1'b1, pc, tk, tgt);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    tests++;
    if (stat_lookups !== 32'h0 || stat_mispred !== 32'h0 || upd_mispred !== 1'b0) begin
      fails++;
      $display("FAIL reset_stats: got lookups=%h mispred=%h pulse=%0b, expected 0/0/0",
               stat_lookups, stat_mispred, upd_mispred);
    end
    step(1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    tests++;
    if (obs_phit !== 1'b0 || obs_baddr !== 32'h0) begin
      fails++;
      $display("FAIL reset_lookup: got phit=%0b baddr=%h, expected 0/0", obs_phit, obs_baddr);
    end
  endtask

  task automatic test_allocate;
    train(32'h40, 1'b1, 32'h100);
    tests++;
    if (obs_mis !== 1'b1) begin
      fails++;
      $display("FAIL alloc_mispred: got %0b, expected 1", obs_mis);
    end
    lookup(32'h40);
    tests++;
    if (obs_phit !== 1'b1 || obs_baddr !== 32'h100) begin
      fails++;
      $display("FAIL alloc_lookup: got phit=%0b baddr=%h, expected 1/00000100", obs_phit, obs_baddr);
    end
  endtask

  task automatic test_hysteresis;
    train(32'h40, 1'b0, 32'h0);
    lookup(32'h40);
    tests++;
    if (obs_phit !== 1'b0) begin
      fails++;
      $display("FAIL hyst_weak_nt: got phit=%0b, expected 0", obs_phit);
    end
    train(32'h40, 1'b1, 32'h100);
    lookup(32'h40);
    tests++;
    if (obs_phit !== 1'b1) begin
      fails++;
      $display("FAIL hyst_weak_t: got phit=%0b, expected 1", obs_phit);
    end
    train(32'h40, 1'b1, 32'h100);
    train(32'h40, 1'b1, 32'h100);
    train(32'h40, 1'b0, 32'h0);
    tests++;
    if (obs_mis !== 1'b1) begin
      fails++;
      $display("FAIL hyst_nt_mispred: got %0b, expected 1", obs_mis);
    end
    lookup(32'h40);
    tests++;
    if (obs_phit !== 1'b1) begin
      fails++;
      $display("FAIL hyst_strong: got phit=%0b, expected 1", obs_phit);
    end
  endtask

  task automatic test_alias;
    lookup(32'h80);
    tests++;
    if (obs_phit !== 1'b0 || obs_baddr !== 32'h100) begin
      fails++;
      $display("FAIL alias_miss: got phit=%0b baddr=%h, expected 0/00000100", obs_phit, obs_baddr);
    end
    train(32'h80, 1'b1, 32'h200);
    lookup(32'h40);
    tests++;
    if (obs_phit !== 1'b0) begin
      fails++;
      $display("FAIL alias_evicted: got phit=%0b, expected 0", obs_phit);
    end
    lookup(32'h80);
    tests++;
    if (obs_phit !== 1'b1 || obs_baddr !== 32'h200) begin
      fails++;
      $display("FAIL alias_new: got phit=%0b baddr=%h, expected 1/00000200", obs_phit, obs_baddr);
    end
  endtask

  task automatic test_hazard;
    train(32'h10, 1'b1, 32'h500);
    step(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h600);
    tests++;
    if (obs_phit !== 1'b1 || obs_baddr !== 32'h500 || obs_mis !== 1'b1) begin
      fails++;
      $display("FAIL hazard_old: got phit=%0b baddr=%h mis=%0b, expected 1/00000500/1",
               obs_phit, obs_baddr, obs_mis);
    end
    lookup(32'h10);
    tests++;
    if (obs_phit !== 1'b1 || obs_baddr !== 32'h600) begin
      fails++;
      $display("FAIL hazard_new: got phit=%0b baddr=%h, expected 1/00000600", obs_phit, obs_baddr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h700);
    tests++;
    if (obs_mis !== 1'b0) begin
      fails++;
      $display("FAIL hazard_rst_mis: got %0b, expected 0", obs_mis);
    end
    lookup(32'h20);
    tests++;
    if (obs_phit !== 1'b0 || obs_baddr !== 32'h0) begin
      fails++;
      $display("FAIL hazard_rst_entry: got phit=%0b baddr=%h, expected 0/0", obs_phit, obs_baddr);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pcs [5];
    pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h10; pcs[3] = 32'h14; pcs[4] = 32'hC0;
    for (int n = 0; n < 60; n++) begin
      step(1'b0, 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)],
           1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)],
           1'($urandom_range(0, 1)), 32'($urandom_range(1, 3)) << 8);
    end
  endtask

  task automatic test_saturation;
    @(negedge CLK);
    #3;
    upd_en = 1'b0; lookup_en = 1'b0;
    force dut.stat_mispred = 32'hFFFF_FFFE;
    #1;
    release dut.stat_mispred;
    m_sm = 32'hFFFF_FFFE;
    train(32'h300, 1'b1, 32'h1);
    tests++;
    if (stat_mispred !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL sat_first: got %h, expected ffffffff", stat_mispred);
    end
    train(32'h700, 1'b1, 32'h2);
    tests++;
    if (stat_mispred !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL sat_hold: got %h, expected ffffffff", stat_mispred);
    end
  endtask

  initial begin
    RST = 1'b1; lookup_en = 1'b0; cpc = '0;
    upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_hazard();
    test_back_to_back();
    test_saturation();
    @(negedge CLK);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
